// File: rtl/matrix_mac_engine_pkg.sv
// Shared types and sizing helpers for the matrix multiply-accumulate engine.
// Widths are derived from N and DW so every file agrees on counter and accumulator sizes.
package matrix_mac_engine_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  localparam int N_DEFAULT  = 2;
  localparam int DW_DEFAULT = 8;

  // Index counter width; never below one bit so N=1 still elaborates.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  // Headroom of ceil(log2 N) bits keeps an N-term dot product from wrapping before saturation.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  localparam int ACC_W_DEFAULT = acc_width(N_DEFAULT, DW_DEFAULT);

endpackage

// File: rtl/matrix_mac_engine_if.sv
// Operand/result streaming bus of the engine, plus its status flags.
// The master drives operands and result backpressure; the slave is the engine.
interface matrix_mac_engine_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/matrix_mac_engine_mac_unit.sv
// Multiply-accumulate datapath: unsigned DW x DW product added to (or replacing) the
// running sum, with the held sum saturated to 2*DW bits for storage.
module mac_unit
  import matrix_mac_engine_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_clr,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [2*DW-1:0] o_sat
);

  localparam int AW = acc_width(N, DW);
  localparam logic [AW-1:0] SAT_MAX = AW'({(2 * DW){1'b1}});

  logic [AW-1:0]   r_acc;
  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   w_sum;

  assign w_prod = (2 * DW)'(i_a) * (2 * DW)'(i_b);
  assign w_sum  = (i_clr ? '0 : r_acc) + AW'(w_prod);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

  assign o_sat = (r_acc > SAT_MAX) ? '1 : r_acc[2*DW-1:0];

endmodule

// File: rtl/matrix_mac_engine.sv
// N x N matrix multiplier: streams in A then B, computes C = A*B one MAC per cycle,
// then streams C out as big-endian byte pairs.
module matrix_mac_engine
  import matrix_mac_engine_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  matrix_mac_engine_if.slave bus
);

  localparam int NN = N * N;
  localparam int IW = clog2_min1(N);
  localparam int EW = clog2_min1(NN);
  localparam int LW = clog2_min1(2 * NN);

  state_e          r_state, w_state_nxt;
  logic [LW-1:0]   r_ld_idx, r_out_idx;
  logic [IW-1:0]   r_i, r_j, r_k;
  logic            r_drain, r_wr_en, r_done;
  logic [EW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_a [NN];
  logic [DW-1:0]   r_b [NN];
  logic [2*DW-1:0] r_c [NN];

  logic            w_in_xfer, w_out_xfer, w_last_ld, w_last_out, w_last_mac, w_mac_en;
  logic [DW-1:0]   w_a_op, w_b_op;
  logic [2*DW-1:0] w_sat;
  logic [15:0]     w_c_out;

  assign w_in_xfer  = (r_state == ST_LOAD) && ena && bus.in_valid;
  assign w_out_xfer = (r_state == ST_OUTPUT) && ena && bus.out_ready;
  assign w_last_ld  = (r_ld_idx == LW'(2 * NN - 1));
  assign w_last_out = (r_out_idx == LW'(2 * NN - 1));
  assign w_last_mac = (r_i == IW'(N - 1)) && (r_j == IW'(N - 1)) && (r_k == IW'(N - 1));
  // The drain cycle after the last MAC writes back the final C element.
  assign w_mac_en   = (r_state == ST_COMPUTE) && ena && !r_drain;

  assign w_a_op  = r_a[EW'(int'(r_i) * N + int'(r_k))];
  assign w_b_op  = r_b[EW'(int'(r_k) * N + int'(r_j))];
  assign w_c_out = 16'(r_c[EW'(r_out_idx >> 1)]);

  mac_unit #(.N(N), .DW(DW)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_mac_en),
    .i_clr (r_k == '0),
    .i_a   (w_a_op),
    .i_b   (w_b_op),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.busy      = (r_state != ST_LOAD);
    bus.done      = r_done;
    case (r_state)
      ST_LOAD: begin
        bus.in_ready = ena && rst_n;
        if (w_in_xfer && w_last_ld) w_state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (ena && r_drain) w_state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        bus.out_valid = ena;
        bus.out_data  = r_out_idx[0] ? w_c_out[7:0] : w_c_out[15:8];
        if (w_out_xfer && w_last_out) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_idx  <= '0;
      r_out_idx <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_drain   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_done    <= 1'b0;
    end else begin
      // A pulse rather than held state: it must drop even if ena falls right after.
      r_done <= w_out_xfer && w_last_out;
      if (ena) begin
        if (w_in_xfer) r_ld_idx <= w_last_ld ? '0 : r_ld_idx + 1'b1;
        if (w_out_xfer) r_out_idx <= w_last_out ? '0 : r_out_idx + 1'b1;
        r_wr_en   <= w_mac_en && (r_k == IW'(N - 1));
        r_wr_addr <= EW'(int'(r_i) * N + int'(r_j));
        if (r_drain) r_drain <= 1'b0;
        if (w_mac_en) begin
          r_k <= (r_k == IW'(N - 1)) ? '0 : r_k + 1'b1;
          if (r_k == IW'(N - 1)) begin
            r_j <= (r_j == IW'(N - 1)) ? '0 : r_j + 1'b1;
            if (r_j == IW'(N - 1)) r_i <= (r_i == IW'(N - 1)) ? '0 : r_i + 1'b1;
          end
          if (w_last_mac) r_drain <= 1'b1;
        end
      end
    end
  end

  // NOTE: operand/result storage has no reset; every job overwrites all entries before use.
  always_ff @(posedge clk) begin
    if (rst_n && ena) begin
      if (w_in_xfer) begin
        if (r_ld_idx < LW'(NN)) r_a[EW'(r_ld_idx)] <= bus.in_data;
        else                    r_b[EW'(r_ld_idx - LW'(NN))] <= bus.in_data;
      end
      if (r_wr_en) r_c[r_wr_addr] <= w_sat;
    end
  end

endmodule
